// File: rtl/pcm_mm_pkg.sv
// Shared types and helpers for the pcm_mm responder: FSM state encoding,
// write-counter ceiling and the byte-lane merge used by read-modify-write.
package pcm_mm_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_FETCH,
        WR_WAIT,
        WR_COMMIT
    } pcm_mm_state_t;

    localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int MERGE_W = 64;

    function automatic logic [MERGE_W-1:0] merge_bytes(
        input logic [MERGE_W-1:0]   old_word,
        input logic [MERGE_W-1:0]   new_word,
        input logic [MERGE_W/8-1:0] be
    );
        logic [MERGE_W-1:0] result;
        result = old_word;
        for (int b = 0; b < MERGE_W/8; b++) begin
            if (be[b]) begin
                result[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/pcm_mm_if.sv
// Avalon-MM style command/response bundle between the arbiter (master) and
// the PCM emulator (slave).
interface pcm_mm_if #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0]   address;
    logic                chipselect;
    logic                clken;
    logic                write;
    logic [DATA_W-1:0]   writedata;
    logic [DATA_W/8-1:0] byteenable;
    logic [DATA_W-1:0]   readdata;
    logic                readdatavalid;
    logic                waitrequest;

    modport master (
        output address, chipselect, clken, write, writedata, byteenable,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, chipselect, clken, write, writedata, byteenable,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/pcm_array.sv
// Single-port synchronous RAM with a registered, write-first read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module pcm_array #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
            rdata     <= wdata;
        end else begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/pcm_mm_responder.sv
// PCM emulator slave: fixed-latency reads, byte-masked read-modify-write with
// a longer commit time, and a saturating count of committed writes.
module pcm_mm_responder
    import pcm_mm_pkg::*;
#(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 16,
    parameter int READ_LATENCY = 2,
    parameter int WRITE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    pcm_mm_if.slave     mm,
    output logic [31:0] write_count
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] RD_LAST       = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0] WR_PRE_COMMIT = CNT_W'(WRITE_CYCLES - 1);
    localparam int BE_W = DATA_W / 8;

    pcm_mm_state_t       state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [BE_W-1:0]     be_reg;
    logic [DATA_W-1:0]   readdata_reg;
    logic                rdv_reg;
    logic                wait_reg;
    logic [31:0]         write_count_reg;

    logic                accept;
    logic                load_rd;
    logic                commit;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_q;
    logic [DATA_W-1:0]   merged_word;

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        accept     = 1'b0;
        load_rd    = 1'b0;
        commit     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mm.chipselect && mm.clken) begin
                    accept     = 1'b1;
                    cnt_next   = CNT_W'(1);
                    state_next = mm.write ? WR_FETCH : READ;
                end
            end
            READ: begin
                if (cnt_reg == RD_LAST) begin
                    load_rd    = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WR_FETCH: begin
                cnt_next   = cnt_reg + CNT_W'(1);
                state_next = (WRITE_CYCLES == 2) ? WR_COMMIT : WR_WAIT;
            end
            WR_WAIT: begin
                if (cnt_reg == WR_PRE_COMMIT) begin
                    state_next = WR_COMMIT;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            WR_COMMIT: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Address the RAM straight from the bus while idle so a read accepted at
    // edge k already has its word on ram_q after that edge (READ_LATENCY==1).
    assign ram_addr    = (state_reg == IDLE) ? mm.address : addr_reg;
    assign ram_we      = commit && (be_reg != '0);
    assign merged_word = DATA_W'(merge_bytes(MERGE_W'(ram_q), MERGE_W'(wdata_reg),
                                             (MERGE_W/8)'(be_reg)));

    pcm_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (merged_word),
        .rdata (ram_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            readdata_reg <= '0;
            rdv_reg      <= 1'b0;
            wait_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            rdv_reg   <= load_rd;
            wait_reg  <= (state_next != IDLE);
            if (load_rd) begin
                readdata_reg <= ram_q;
            end
        end
    end

    // Only assigned on a counted commit, so the value is held otherwise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_count_reg <= '0;
        end else if (ram_we && (write_count_reg != COUNT_MAX)) begin
            write_count_reg <= write_count_reg + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_reg  <= mm.address;
            wdata_reg <= mm.writedata;
            be_reg    <= mm.byteenable;
        end
    end

    assign mm.readdata      = readdata_reg;
    assign mm.readdatavalid = rdv_reg;
    assign mm.waitrequest   = wait_reg;
    assign write_count      = write_count_reg;

endmodule
